// File: rtl/btn_sw_bounce_bfm_pkg.sv
// Shared types and helpers for the push-button / slider-switch bounce BFM family.
package btn_sw_bfm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } bfm_state_t;

  localparam int              LFSR_W    = 16;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
  endfunction

endpackage

// File: rtl/btn_sw_bounce_bfm_if.sv
// Command handshake between a board testbench (master) and the bounce BFM (slave).
interface btn_sw_bounce_bfm_if #(
  parameter int CHAN_W = 4
);
  logic              BOUNCE_EN;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [CHAN_W-1:0] CMD_CHAN;
  logic              CMD_LEVEL;
  logic              DONE;
  logic              ERR;

  modport master (
    output BOUNCE_EN, CMD_VALID, CMD_CHAN, CMD_LEVEL,
    input  CMD_READY, DONE, ERR
  );

  modport slave (
    input  BOUNCE_EN, CMD_VALID, CMD_CHAN, CMD_LEVEL,
    output CMD_READY, DONE, ERR
  );
endinterface

// File: rtl/btn_sw_bounce_bfm_lfsr16.sv
// 16-bit Galois LFSR that steps only when asked, so the bounce pattern depends
// solely on the seed and how many bounce cycles have been consumed.
module bfm_lfsr16
  import btn_sw_bfm_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic lsb
);

  localparam logic [LFSR_W-1:0] SEED_SAFE = safe_seed(SEED);

  logic [LFSR_W-1:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED_SAFE;
    end else if (adv) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

  assign lsb = state[0];

endmodule

// File: rtl/btn_sw_bounce_bfm.sv
// Board button/switch BFM: one command at a time drives a single line to a new
// level, optionally through an LFSR contact-bounce burst, then a settle window.
module btn_sw_bounce_bfm
  import btn_sw_bfm_pkg::*;
#(
  parameter int          NUM_BTN       = 4,
  parameter int          NUM_SW        = 8,
  parameter int          BOUNCE_CYCLES = 16,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      CLK,
  input  logic                      RST_ASYNC,
  btn_sw_bounce_bfm_if.slave        cmd,
  output logic [NUM_BTN-1:0]        BTN,
  output logic [NUM_SW-1:0]         SW,
  output logic [NUM_BTN+NUM_SW-1:0] STATUS
);

  localparam int NUM_CH  = NUM_BTN + NUM_SW;
  localparam int CHAN_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (BOUNCE_CYCLES > SETTLE_CYCLES) ? BOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BOUNCE_END = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES);
  localparam logic [CHAN_W:0]   CHAN_LIMIT = (CHAN_W + 1)'(NUM_CH);
  localparam logic              BOUNCE_ON  = (BOUNCE_CYCLES > 0);
  localparam logic              DONE_ENTRY = (SETTLE_END == CNT_ONE);

  bfm_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] lines_q;
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] sel_q;
  logic              level_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [NUM_CH-1:0] cmd_sel;
  logic              cmd_bad;
  logic              cmd_same;
  logic              start_bounce;
  logic              lfsr_adv;
  logic              lfsr_lsb;

  // Replace the selected bits of a channel vector with one level.
  function automatic logic [NUM_CH-1:0] set_chan(input logic [NUM_CH-1:0] cur,
                                                 input logic [NUM_CH-1:0] sel,
                                                 input logic              lvl);
    return (cur & ~sel) | (sel & {NUM_CH{lvl}});
  endfunction

  assign accept       = cmd.CMD_VALID && (state == IDLE);
  assign cmd_sel      = NUM_CH'(1) << cmd.CMD_CHAN;
  // One extra bit keeps the range test from wrapping when NUM_CH is a power of two.
  assign cmd_bad      = ({1'b0, cmd.CMD_CHAN} >= CHAN_LIMIT);
  assign cmd_same     = (((status_q & cmd_sel) != '0) == cmd.CMD_LEVEL);
  assign start_bounce = cmd.BOUNCE_EN && BOUNCE_ON;

  // The LFSR steps exactly once for every bounce value driven onto a line.
  assign lfsr_adv = (accept && !cmd_bad && !cmd_same && start_bounce) ||
                    ((state == BOUNCE) && (cnt != BOUNCE_END));

  bfm_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (CLK),
    .rst (RST_ASYNC),
    .adv (lfsr_adv),
    .lsb (lfsr_lsb)
  );

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state    <= IDLE;
      cnt      <= '0;
      lines_q  <= '0;
      status_q <= '0;
      sel_q    <= '0;
      level_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.CMD_VALID) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else if (cmd_same) begin
              done_q <= 1'b1;
            end else begin
              sel_q   <= cmd_sel;
              level_q <= cmd.CMD_LEVEL;
              cnt     <= CNT_ONE;
              if (start_bounce) begin
                lines_q <= set_chan(lines_q, cmd_sel, lfsr_lsb);
                state   <= BOUNCE;
              end else begin
                lines_q  <= set_chan(lines_q, cmd_sel, cmd.CMD_LEVEL);
                status_q <= set_chan(status_q, cmd_sel, cmd.CMD_LEVEL);
                done_q   <= DONE_ENTRY;
                state    <= SETTLE;
              end
            end
          end
        end
        BOUNCE: begin
          if (cnt == BOUNCE_END) begin
            lines_q  <= set_chan(lines_q, sel_q, level_q);
            status_q <= set_chan(status_q, sel_q, level_q);
            cnt      <= CNT_ONE;
            done_q   <= DONE_ENTRY;
            state    <= SETTLE;
          end else begin
            lines_q <= set_chan(lines_q, sel_q, lfsr_lsb);
            cnt     <= cnt + CNT_ONE;
          end
        end
        SETTLE: begin
          // DONE is raised on entry to the final settle cycle.
          if (cnt == SETTLE_END) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt    <= cnt + CNT_ONE;
            done_q <= ((cnt + CNT_ONE) == SETTLE_END);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd.CMD_READY = (state == IDLE);
  assign cmd.DONE      = done_q;
  assign cmd.ERR       = err_q;
  assign BTN           = lines_q[NUM_BTN-1:0];
  assign SW            = lines_q[NUM_CH-1:NUM_BTN];
  assign STATUS        = status_q;

endmodule

// File: tb/tb_btn_sw_bounce_bfm.sv
// Self-checking bench for btn_sw_bounce_bfm: command table plus hand-built corner sequences.
module tb_btn_sw_bounce_bfm;

  localparam int          NUM_BTN = 4;
  localparam int          NUM_SW  = 8;
  localparam int          NUM_CH  = NUM_BTN + NUM_SW;
  localparam int          CHAN_W  = 4;
  localparam int          BOUNCE  = 16;
  localparam int          SETTLE  = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_BTN-1:0] btn;
  logic [NUM_SW-1:0]  sw;
  logic [NUM_CH-1:0]  status;

  btn_sw_bounce_bfm_if #(.CHAN_W(CHAN_W)) cmd_if ();

  btn_sw_bounce_bfm #(
    .NUM_BTN       (NUM_BTN),
    .NUM_SW        (NUM_SW),
    .BOUNCE_CYCLES (BOUNCE),
    .SETTLE_CYCLES (SETTLE),
    .LFSR_SEED     (SEED)
  ) dut (
    .CLK       (clk),
    .RST_ASYNC (rst),
    .cmd       (cmd_if),
    .BTN       (btn),
    .SW        (sw),
    .STATUS    (status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              ready;
    logic              done;
    logic              err;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] lines;
  } obs_t;

  typedef struct {
    int                chan;
    bit                lvl;
    bit                ben;
    bit                exp_err;
    int                exp_lat;
    logic [NUM_CH-1:0] exp_status;
  } vec_t;

  obs_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [NUM_CH-1:0] m_lines;
  logic [NUM_CH-1:0] m_status;
  logic [15:0]       m_lfsr;
  vec_t              vecs[10];

  function automatic logic [15:0] galois_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic obs_t mk(input bit r, input bit d, input bit e);
    return {r, d, e, m_status, m_lines};
  endfunction

  // Reference behaviour: one record per cycle after the accepting edge.
  function automatic void model_cmd(input int chan, input bit lvl, input bit ben);
    if (chan >= NUM_CH) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
      return;
    end
    if (m_status[chan] == lvl) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
      return;
    end
    if (ben) begin
      for (int i = 0; i < BOUNCE; i++) begin
        m_lines[chan] = m_lfsr[0];
        m_lfsr        = galois_step(m_lfsr);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
      end
    end
    m_lines[chan]  = lvl;
    m_status[chan] = lvl;
    for (int i = 1; i <= SETTLE; i++) exp_q.push_back(mk(1'b0, i == SETTLE, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
  endfunction

  function automatic obs_t observe();
    return {cmd_if.CMD_READY, cmd_if.DONE, cmd_if.ERR, status, sw, btn};
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got rdy=%b done=%b err=%b status=%h lines=%h, want rdy=%b done=%b err=%b status=%h lines=%h",
               name, $time, act.ready, act.done, act.err, act.status, act.lines,
               exp.ready, exp.done, exp.err, exp.status, exp.lines);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  // Accept on the coming edge, then scramble the bus so late capture would show.
  task automatic accept_now(input int chan, input bit lvl, input bit ben);
    @(posedge clk);
    model_cmd(chan, lvl, ben);
    #1;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_CHAN  = CHAN_W'($urandom);
    cmd_if.CMD_LEVEL = 1'($urandom);
    cmd_if.BOUNCE_EN = 1'($urandom);
  endtask

  task automatic send(input int chan, input bit lvl, input bit ben);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_if.CMD_CHAN  = CHAN_W'(chan);
    cmd_if.CMD_LEVEL = lvl;
    cmd_if.BOUNCE_EN = ben;
    cmd_if.CMD_VALID = 1'b1;
    while (cmd_if.CMD_READY !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        $display("FAIL ready_timeout: CMD_READY stayed %b, want 1", cmd_if.CMD_READY);
        $fatal(1);
      end
    end
    accept_now(chan, lvl, ben);
  endtask

  task automatic drain(output int done_at, output bit err_seen);
    obs_t a, e;
    int   n;
    n        = 0;
    done_at  = 0;
    err_seen = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      e = exp_q.pop_front();
      a = observe();
      if (a.done === 1'b1 && done_at == 0) done_at = n;
      if (a.err === 1'b1) err_seen = 1'b1;
      check_obs("trace", a, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int   lat;
    bit   err_seen;
    obs_t a, e;

    vecs[0] = '{2,  1'b1, 1'b0, 1'b0, 4,  12'h004};
    vecs[1] = '{4,  1'b1, 1'b1, 1'b0, 20, 12'h014};
    vecs[2] = '{15, 1'b1, 1'b1, 1'b1, 0,  12'h014};
    vecs[3] = '{2,  1'b1, 1'b1, 1'b0, 1,  12'h014};
    vecs[4] = '{11, 1'b1, 1'b1, 1'b0, 20, 12'h814};
    vecs[5] = '{2,  1'b0, 1'b0, 1'b0, 4,  12'h810};
    vecs[6] = '{12, 1'b0, 1'b0, 1'b1, 0,  12'h810};
    vecs[7] = '{0,  1'b1, 1'b1, 1'b0, 20, 12'h811};
    vecs[8] = '{4,  1'b0, 1'b1, 1'b0, 20, 12'h801};
    vecs[9] = '{4,  1'b0, 1'b0, 1'b0, 1,  12'h801};

    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_CHAN  = '0;
    cmd_if.CMD_LEVEL = 1'b0;
    cmd_if.BOUNCE_EN = 1'b0;
    m_lines  = '0;
    m_status = '0;
    m_lfsr   = SEED;

    // Reset state, then release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs", {5'd0, cmd_if.DONE, cmd_if.ERR, status, sw, btn}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_obs("after_reset", observe(), mk(1'b1, 1'b0, 1'b0));

    for (int v = 0; v < 10; v++) begin
      send(vecs[v].chan, vecs[v].lvl, vecs[v].ben);
      drain(lat, err_seen);
      check_val($sformatf("vec%0d_done_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check_val($sformatf("vec%0d_err", v), {31'd0, err_seen}, {31'd0, vecs[v].exp_err});
      check_val($sformatf("vec%0d_status", v), {20'd0, status}, {20'd0, vecs[v].exp_status});
    end

    // Second command held on the bus throughout the first must wait for READY
    send(5, 1'b1, 1'b0);
    cmd_if.CMD_CHAN  = CHAN_W'(6);
    cmd_if.CMD_LEVEL = 1'b1;
    cmd_if.BOUNCE_EN = 1'b1;
    cmd_if.CMD_VALID = 1'b1;
    drain(lat, err_seen);
    check_val("held_first_latency", 32'(lat), 32'd4);
    accept_now(6, 1'b1, 1'b1);
    drain(lat, err_seen);
    check_val("held_second_latency", 32'(lat), 32'd20);
    check_val("held_status", {20'd0, status}, {20'd0, 12'h861});

    // Reset in the middle of a bounce burst
    send(4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = observe();
      check_obs("pre_reset_bounce", a, e);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("midreset_outputs", {5'd0, cmd_if.DONE, cmd_if.ERR, status, sw, btn}, 32'd0);
    exp_q.delete();
    m_lines  = '0;
    m_status = '0;
    m_lfsr   = SEED;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_obs("ready_after_midreset", observe(), mk(1'b1, 1'b0, 1'b0));

    // Bounce after reset must replay the pattern from the seed
    send(4, 1'b1, 1'b1);
    drain(lat, err_seen);
    check_val("replay_latency", 32'(lat), 32'd20);
    check_val("replay_status", {20'd0, status}, {20'd0, 12'h010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
